// File: rtl/line_raster.sv
// line_raster: Bresenham line rasteriser. Emits one frame address per pixel from (X0,Y0) to
// (X1,Y1) under sink back-pressure, skipping off-screen pixels, with abort and a done pulse.
module line_raster #(
   parameter int unsigned COORD_W     = 8,
   parameter int unsigned PIXELS_LINE = 240,
   parameter int unsigned LINES       = 160,
   parameter int unsigned ADR_W       = 16
) (
   input  logic               iClk,
   input  logic               iRst_n,
   input  logic               iGo,
   input  logic               iAbort,
   input  logic [COORD_W-1:0] iX0,
   input  logic [COORD_W-1:0] iY0,
   input  logic [COORD_W-1:0] iX1,
   input  logic [COORD_W-1:0] iY1,
   input  logic               iWrRdy,
   output logic [ADR_W-1:0]   oAdr,
   output logic               oWrEn,
   output logic               oBusy,
   output logic               oDone,
   output logic [COORD_W:0]   oCount
);

   localparam int unsigned E_W = COORD_W + 3;

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, DRAW = 2'd2} state_t;

   state_t                r_state, w_state_nxt;
   logic [COORD_W-1:0]    r_cx, r_cy, r_x1, r_y1;
   logic signed [E_W-1:0] r_dx, r_dy, r_err;
   logic                  r_sx_neg, r_sy_neg, r_done;
   logic [COORD_W:0]      r_count;

   logic                  w_start, w_draw, w_vis, w_last, w_step, w_acc, w_tx, w_ty;
   logic [COORD_W-1:0]    w_dx_abs, w_dy_abs;
   logic signed [E_W-1:0] w_e2, w_err_nxt;

   assign w_start = (r_state == IDLE) && iGo && !iAbort;
   assign w_draw  = (r_state == DRAW) && !iAbort;
   assign w_vis   = (32'(r_cx) < PIXELS_LINE) && (32'(r_cy) < LINES);
   assign w_last  = (r_cx == r_x1) && (r_cy == r_y1);
   // Off-screen cursors advance without waiting for the sink.
   assign w_step  = w_draw && (!w_vis || iWrRdy);
   assign w_acc   = w_draw && w_vis && iWrRdy;

   // During SETUP the cursor still holds the start point.
   assign w_dx_abs = (r_x1 >= r_cx) ? r_x1 - r_cx : r_cx - r_x1;
   assign w_dy_abs = (r_y1 >= r_cy) ? r_y1 - r_cy : r_cy - r_y1;

   assign w_e2 = r_err <<< 1;
   assign w_tx = w_e2 > -r_dy;
   assign w_ty = w_e2 < r_dx;

   always_comb begin
      w_err_nxt = r_err;
      if (w_tx) w_err_nxt = w_err_nxt - r_dy;
      if (w_ty) w_err_nxt = w_err_nxt + r_dx;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_start) w_state_nxt = SETUP;
         SETUP:   w_state_nxt = iAbort ? IDLE : DRAW;
         DRAW:    if (iAbort || (w_step && w_last)) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_cx     <= '0;
         r_cy     <= '0;
         r_x1     <= '0;
         r_y1     <= '0;
         r_dx     <= '0;
         r_dy     <= '0;
         r_err    <= '0;
         r_sx_neg <= 1'b0;
         r_sy_neg <= 1'b0;
         r_done   <= 1'b0;
         r_count  <= '0;
      end else begin
         r_done <= w_step && w_last;
         if (w_start) begin
            r_cx    <= iX0;
            r_cy    <= iY0;
            r_x1    <= iX1;
            r_y1    <= iY1;
            r_count <= '0;
         end else if (r_state == SETUP) begin
            r_dx     <= $signed({3'b000, w_dx_abs});
            r_dy     <= $signed({3'b000, w_dy_abs});
            r_err    <= $signed({3'b000, w_dx_abs}) - $signed({3'b000, w_dy_abs});
            r_sx_neg <= r_x1 < r_cx;
            r_sy_neg <= r_y1 < r_cy;
         end else if (w_step) begin
            if (w_acc) r_count <= r_count + 1'b1;
            if (!w_last) begin
               r_err <= w_err_nxt;
               if (w_tx) r_cx <= r_sx_neg ? r_cx - 1'b1 : r_cx + 1'b1;
               if (w_ty) r_cy <= r_sy_neg ? r_cy - 1'b1 : r_cy + 1'b1;
            end
         end
      end
   end

   assign oAdr   = ADR_W'(32'(r_cy) * PIXELS_LINE + 32'(r_cx));
   assign oWrEn  = w_draw && w_vis;
   assign oBusy  = (r_state != IDLE);
   assign oDone  = r_done;
   assign oCount = r_count;

endmodule

// File: doc/line_raster.md
LINE_RASTER -- requirements
Module: line_raster

Interface
REQ-001 Parameter COORD_W, default 8: coordinate width in bits, unsigned.
REQ-002 Parameter PIXELS_LINE, default 240: frame width in pixels and address stride per row.
REQ-003 Parameter LINES, default 160: frame height in rows.
REQ-004 Parameter ADR_W, default 16: frame address width.
REQ-005 iClk  in  1  sole clock; all state changes on the rising edge.
REQ-006 iRst_n  in  1  asynchronous reset, active-low.
REQ-007 iGo  in  1  start request, sampled only in IDLE.
REQ-008 iAbort  in  1  cancel the current line.
REQ-009 iX0, iY0, iX1, iY1  in  COORD_W each  start and end points, sampled with iGo.
REQ-010 iWrRdy  in  1  frame sink accepts the current pixel.
REQ-011 oAdr  out  ADR_W  pixel address = y*PIXELS_LINE + x.
REQ-012 oWrEn  out  1  pixel valid.
REQ-013 oBusy  out  1  high in SETUP and DRAW.
REQ-014 oDone  out  1  one-cycle pulse on line completion.
REQ-015 oCount  out  COORD_W+1  pixels accepted for the current or last line.

Function
REQ-016 The block SHALL implement FSM states IDLE, SETUP and DRAW.
REQ-017 IDLE, iGo=1, iAbort=0: latch points, clear oCount, go to SETUP; iGo outside IDLE ignored.
REQ-018 SETUP SHALL last exactly one cycle: dx=|X1-X0|, dy=|Y1-Y0|, sx/sy=+1/-1 toward endpoint (+1 when equal), err=dx-dy, cursor=(X0,Y0); then DRAW.
REQ-019 Arithmetic SHALL be signed, COORD_W+3 bits for err and 2*err; there is no overflow for any input.
REQ-020 Step rule, e2=2*err: if e2>-dy then err-=dy, x+=sx; if e2<dx then err+=dx, y+=sy; both tests use pre-step e2.
REQ-021 Pixels SHALL be emitted in order from (X0,Y0) to (X1,Y1) inclusive with no point swapping; the count equals max(dx,dy)+1.
REQ-022 The first oWrEn SHALL assert two cycles after iGo is sampled (iGo cycle N; SETUP N+1; pixel valid N+2).
REQ-023 A pixel is accepted on the cycle oWrEn=1 and iWrRdy=1; the cursor advances only on accept or on a clipped step.
REQ-024 While oWrEn=1 and iWrRdy=0, oAdr and oWrEn SHALL hold stable.
REQ-025 With iWrRdy held high, one pixel SHALL be emitted per cycle with no bubbles.
REQ-026 Clipping: a cursor with x>=PIXELS_LINE or y>=LINES SHALL force oWrEn=0 and step on the next cycle; oCount is not incremented.
REQ-027 The step producing cursor==(X1,Y1) is the last: after its accept (or clip), return to IDLE and pulse oDone for one cycle in IDLE.
REQ-028 iAbort=1 in SETUP or DRAW: IDLE next cycle, oWrEn=0 that cycle, no oDone, oCount keeps its accepted value.
REQ-029 iAbort and iGo both high in IDLE: iAbort wins, stay IDLE.
REQ-030 X0=X1 and Y0=Y1 SHALL produce exactly one pixel followed by oDone.
REQ-031 oAdr SHALL be computed from the registered cursor and truncated to ADR_W.

Reset
REQ-032 iRst_n=0 SHALL force IDLE immediately with oWrEn=0, oBusy=0, oDone=0, oAdr=0 and oCount=0, regardless of clock.
REQ-033 Reset mid-line SHALL discard the line; after release, the block accepts iGo on the first rising edge.

Verification
REQ-034 (0,0)->(3,0), iWrRdy=1 -> oAdr 0,1,2,3 on cycles N+2..N+5; oDone at N+6; oCount=4.
REQ-035 (2,5)->(0,0) -> oAdr 1202,962,721,481,240,0, then oDone; oCount=6.
REQ-036 Same as REQ-034 with iWrRdy=0 for 3 cycles while oAdr=1 -> oAdr=1 held 4 cycles, no pixel lost or repeated; oDone at N+9.
REQ-037 (5,5)->(5,5) -> single write to oAdr 1205, then oDone; oCount=1.
REQ-038 COORD_W=9, (238,0)->(241,0) -> writes 238 and 239 only, 2 clipped cycles, oDone, oCount=2.
REQ-039 iAbort on the 3rd pixel of (0,0)->(9,0) -> oWrEn low next cycle, no oDone, oCount=2; repeat with iRst_n low instead -> all outputs 0 asynchronously.
